// File: rtl/axi_pkg.sv
// Shared AXI encodings and arbiter state type for the read-channel arbiter.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_AR,
    ARB_R
  } arb_state_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant select; gnt is the index of the chosen master.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) begin
      // Contention: round-robin favours the master not served last, else m1 wins.
      gnt = rr_en ? ~last : 1'b1;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: one burst per grant, R routed back until rlast.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_araddr,
  input  logic          m0_arvalid,
  input  logic [1:0]    m0_arburst,
  input  logic [LW-1:0] m0_arlen,
  input  logic [2:0]    m0_arsize,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rvalid,
  output logic          m0_rlast,
  input  logic          m0_rready,
  input  logic [AW-1:0] m1_araddr,
  input  logic          m1_arvalid,
  input  logic [1:0]    m1_arburst,
  input  logic [LW-1:0] m1_arlen,
  input  logic [2:0]    m1_arsize,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rvalid,
  output logic          m1_rlast,
  input  logic          m1_rready,
  output logic [AW-1:0] s_araddr,
  output logic          s_arvalid,
  output logic [1:0]    s_arburst,
  output logic [LW-1:0] s_arlen,
  output logic [2:0]    s_arsize,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rvalid,
  input  logic          s_rlast,
  output logic          s_rready,
  output logic          busy,
  output logic [LW-1:0] beat_cnt
);

  arb_state_t    state_q, state_d;
  logic          grant_q, grant_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic          pick;
  logic          last_srv;
  logic          rr_en;
  logic          mg_arvalid;
  logic          mg_rready;
  logic          sel0_r, sel1_r;

`ifdef ARB_RR_EN
  logic last_q;

  assign rr_en    = 1'b1;
  assign last_srv = last_q;

  // Last-served follows the grant taken on entry to AR.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_M1;
    end else if (state_q == ARB_IDLE && (m0_arvalid || m1_arvalid)) begin
      last_q <= pick;
    end
  end
`else
  assign rr_en    = 1'b0;
  assign last_srv = 1'b0;
`endif

  arb_pick2 u_pick (
    .req   ({m1_arvalid, m0_arvalid}),
    .last  (last_srv),
    .rr_en (rr_en),
    .gnt   (pick)
  );

  assign mg_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign mg_rready  = grant_q ? m1_rready  : m0_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GNT_M0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_d = pick;
          state_d = ARB_AR;
        end
      end
      ARB_AR: begin
        // A master dropping arvalid before the handshake abandons the burst.
        if (!mg_arvalid) begin
          state_d = ARB_IDLE;
        end else if (s_arready) begin
          beat_cnt_d = '0;
          state_d    = ARB_R;
        end
      end
      ARB_R: begin
        if (s_rvalid && mg_rready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (s_rlast) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_araddr  = grant_q ? m1_araddr  : m0_araddr;
    s_arburst = grant_q ? m1_arburst : m0_arburst;
    s_arlen   = grant_q ? m1_arlen   : m0_arlen;
    s_arsize  = grant_q ? m1_arsize  : m0_arsize;
    s_arvalid = (state_q == ARB_AR) && mg_arvalid;

    m0_arready = (state_q == ARB_AR) && (grant_q == GNT_M0) && s_arready;
    m1_arready = (state_q == ARB_AR) && (grant_q == GNT_M1) && s_arready;

    sel0_r = (state_q == ARB_R) && (grant_q == GNT_M0);
    sel1_r = (state_q == ARB_R) && (grant_q == GNT_M1);

    s_rready = (state_q == ARB_R) && mg_rready;

    m0_rvalid = sel0_r && s_rvalid;
    m0_rlast  = sel0_r && s_rlast;
    m0_rdata  = sel0_r ? s_rdata : '0;
    m0_rresp  = sel0_r ? s_rresp : 2'b00;

    m1_rvalid = sel1_r && s_rvalid;
    m1_rlast  = sel1_r && s_rlast;
    m1_rdata  = sel1_r ? s_rdata : '0;
    m1_rresp  = sel1_r ? s_rresp : 2'b00;

    busy     = (state_q != ARB_IDLE);
    beat_cnt = beat_cnt_q;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with a simple in-order memory slave model.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          m;
  } ar_t;

  typedef struct {
    logic          m;
    logic [DW-1:0] data;
    logic          last;
  } r_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m1_arvalid, s_arvalid;
  logic [1:0]    m0_arburst, m1_arburst, s_arburst;
  logic [LW-1:0] m0_arlen, m1_arlen, s_arlen;
  logic [2:0]    m0_arsize, m1_arsize, s_arsize;
  logic          m0_arready, m1_arready, s_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          m0_rvalid, m1_rvalid, s_rvalid;
  logic          m0_rlast, m1_rlast, s_rlast;
  logic          m0_rready, m1_rready, s_rready;
  logic          busy;
  logic [LW-1:0] beat_cnt;

  axi_rd_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arburst(m0_arburst),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arburst(m1_arburst),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arburst(s_arburst),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  ar_t exp_ar[$];
  r_t  exp_r[$];
  ar_t req0[$], req1[$];
  ar_t slv_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  rlast_cyc = 0;
  int  ar_cyc = 0;
  logic stray = 1'b0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
    return {a, 24'h0, 8'(i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_burst(input logic m, input logic [AW-1:0] a, input int len);
    ar_t e;
    r_t  b;
    e.addr = a;
    e.len  = LW'(len);
    e.m    = m;
    exp_ar.push_back(e);
    for (int i = 0; i <= len; i++) begin
      b.m    = m;
      b.data = beat_data(a, i);
      b.last = (i == len);
      exp_r.push_back(b);
    end
  endtask

  task automatic request(input logic m, input logic [AW-1:0] a, input int len);
    ar_t r;
    r.addr = a;
    r.len  = LW'(len);
    r.m    = m;
    if (m) req1.push_back(r);
    else   req0.push_back(r);
  endtask

  // Master AR drivers: hold arvalid until the handshake, then take the next request.
  initial begin
    logic hs0, hs1;
    ar_t  r;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0;
    m0_arburst = AXI_BURST_INCR; m0_arsize = 3'd3;
    m1_arburst = AXI_BURST_INCR; m1_arsize = 3'd3;
    forever begin
      @(negedge clk);
      hs0 = m0_arvalid && m0_arready;
      hs1 = m1_arvalid && m1_arready;
      @(posedge clk);
      #2;
      if (hs0) m0_arvalid = 1'b0;
      if (hs1) m1_arvalid = 1'b0;
      if (!m0_arvalid && req0.size() > 0) begin
        r = req0.pop_front();
        m0_araddr = r.addr; m0_arlen = r.len; m0_arvalid = 1'b1;
      end
      if (!m1_arvalid && req1.size() > 0) begin
        r = req1.pop_front();
        m1_araddr = r.addr; m1_arlen = r.len; m1_arvalid = 1'b1;
      end
    end
  end

  // Memory slave: always ready for AR, returns arlen+1 beats in order.
  initial begin
    logic          ar_hs, r_hs, rs;
    logic [AW-1:0] cap_addr;
    logic [LW-1:0] cap_len;
    int            beat;
    ar_t           n;
    beat = 0;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = AXI_RESP_OKAY; s_rlast = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      rs    = rst;
      cap_addr = s_araddr;
      cap_len  = s_arlen;
      @(posedge clk);
      #1;
      if (rs) begin
        slv_q.delete();
        beat = 0;
      end else begin
        if (r_hs && slv_q.size() > 0) begin
          if (beat == int'(slv_q[0].len)) begin
            void'(slv_q.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        if (ar_hs) begin
          n.addr = cap_addr; n.len = cap_len; n.m = 1'b0;
          slv_q.push_back(n);
        end
      end
      if (slv_q.size() > 0) begin
        s_rvalid = 1'b1;
        s_rdata  = beat_data(slv_q[0].addr, beat);
        s_rlast  = (beat == int'(slv_q[0].len));
      end else begin
        s_rvalid = stray;
        s_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        s_rlast  = stray;
      end
    end
  end

  task automatic pop_r(input logic m);
    r_t e;
    if (exp_r.size() == 0) begin
      checks++; errors++;
      $display("FAIL r_unexpected: beat on m%0d with nothing expected", m);
      return;
    end
    e = exp_r.pop_front();
    check("r_master", m, e.m);
    check("r_data", m ? m1_rdata : m0_rdata, e.data);
    check("r_last", m ? m1_rlast : m0_rlast, e.last);
    check("r_other_rvalid", m ? m0_rvalid : m1_rvalid, 0);
    if (e.last) rlast_cyc = cyc;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an AR or an R beat.
  initial begin
    ar_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_arvalid && s_arready) begin
        ar_cyc = cyc;
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: addr %0h issued with nothing expected", s_araddr);
        end else begin
          e = exp_ar.pop_front();
          check("ar_addr", s_araddr, e.addr);
          check("ar_len", s_arlen, e.len);
          check("ar_granted_ready", e.m ? m1_arready : m0_arready, 1);
          check("ar_other_ready", e.m ? m0_arready : m1_arready, 0);
        end
      end
      if (m0_rvalid && m0_rready) pop_r(1'b0);
      if (m1_rvalid && m1_rready) pop_r(1'b1);
    end
  end

  task automatic wait_rlast(input logic m);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("other_arready_held", m ? m0_arready : m1_arready, 0);
      if (m && m1_rvalid && m1_rready && m1_rlast) return;
      if (!m && m0_rvalid && m0_rready && m0_rlast) return;
    end
    checks++; errors++;
    $display("FAIL rlast_timeout: m%0d got no rlast within 100 cycles, required one", m);
  endtask

  task automatic wait_beat(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m0_rvalid && int'(beat_cnt) == n) return;
    end
    checks++; errors++;
    $display("FAIL beat_timeout: beat_cnt never reached %0d", n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int r0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_m0_arready", m0_arready, 0);
    check("rst_m1_arready", m1_arready, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_rready", s_rready, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single m0 burst of 9 beats
    request(1'b0, 32'h8000_0040, 8);
    expect_burst(1'b0, 32'h8000_0040, 8);
    wait_rlast(1'b0);
    @(negedge clk);
    check("t1_busy_after_rlast", busy, 0);
    check("t1_beat_cnt", beat_cnt, 9);

    // 2: simultaneous requests from a fresh reset (last-served = m1)
    do_reset();
    request(1'b0, 32'h0000_1000, 1);
    request(1'b1, 32'h0000_2000, 2);
`ifdef ARB_RR_EN
    expect_burst(1'b0, 32'h0000_1000, 1);
    expect_burst(1'b1, 32'h0000_2000, 2);
    wait_rlast(1'b0);
    wait_rlast(1'b1);
`else
    expect_burst(1'b1, 32'h0000_2000, 2);
    expect_burst(1'b0, 32'h0000_1000, 1);
    wait_rlast(1'b1);
    wait_rlast(1'b0);
`endif

    // 3: m1 requests mid-way through m0's burst
    @(posedge clk); #1;
    request(1'b0, 32'h0000_3000, 3);
    expect_burst(1'b0, 32'h0000_3000, 3);
    expect_burst(1'b1, 32'h0000_4000, 0);
    repeat (3) @(posedge clk);
    #1 request(1'b1, 32'h0000_4000, 0);
    wait_rlast(1'b0);
    @(posedge clk);
    r0 = rlast_cyc;
    wait_rlast(1'b1);
    check("t3_grant_gap", ar_cyc - r0, 2);

    // 4: m0 back-pressure for three cycles
    @(posedge clk); #1;
    request(1'b0, 32'h0000_5000, 3);
    expect_burst(1'b0, 32'h0000_5000, 3);
    wait_beat(1);
    @(posedge clk); #1 m0_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_s_rready", s_rready, 0);
      check("t4_beat_cnt_hold", beat_cnt, 2);
      check("t4_m0_rvalid_held", m0_rvalid, 1);
    end
    @(posedge clk); #1 m0_rready = 1'b1;
    wait_rlast(1'b0);
    @(negedge clk);
    check("t4_beat_cnt_final", beat_cnt, 4);

    // 5: reset at beat 4 of 9
    @(posedge clk); #1;
    request(1'b0, 32'h0000_6000, 8);
    expect_burst(1'b0, 32'h0000_6000, 8);
    wait_beat(4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_beat_cnt", beat_cnt, 0);
    check("t5_m0_rvalid", m0_rvalid, 0);
    check("t5_m1_rvalid", m1_rvalid, 0);
    check("t5_s_arvalid", s_arvalid, 0);
    check("t5_s_rready", s_rready, 0);
    check("t5_m0_arready", m0_arready, 0);
    exp_r.delete();
    @(posedge clk); #1;
    request(1'b0, 32'h0000_7000, 1);
    expect_burst(1'b0, 32'h0000_7000, 1);
    wait_rlast(1'b0);

    // 6: stray s_rvalid while idle
    @(posedge clk); #1 stray = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_m0_rvalid", m0_rvalid, 0);
    check("t6_m1_rvalid", m1_rvalid, 0);
    check("t6_s_rready", s_rready, 0);
    @(posedge clk); #1 stray = 1'b0;

    repeat (3) @(negedge clk);
    check("end_exp_r_empty", exp_r.size(), 0);
    check("end_exp_ar_empty", exp_ar.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
